// File: rtl/tpu_pkg.sv
// Shared TPU definitions: array geometry, result width
// and collector state encoding.
package tpu_pkg;

   localparam int ARRAY_SIZE   = 3;
   localparam int RESULT_W     = 16;
   localparam int PACKED_WORDS = 5;

   localparam logic [1:0] COL_IDLE    = 2'd0;
   localparam logic [1:0] COL_CAPTURE = 2'd1;
   localparam logic [1:0] COL_DONE    = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE    = COL_IDLE,
      ST_CAPTURE = COL_CAPTURE,
      ST_DONE    = COL_DONE
   } col_state_t;

endpackage

// File: rtl/sysa_collector.sv
// De-skews staggered systolic column outputs into a
// result buffer and serves it as packed 32-bit words.
module sysa_collector
   import tpu_pkg::*;
#(
   parameter int ROWS = ARRAY_SIZE,
   parameter int COLS = ARRAY_SIZE,
   parameter int DW   = RESULT_W,
   parameter int RELU = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] out1,
   input  logic [DW-1:0] out2,
   input  logic [DW-1:0] out3,
   input  logic          rd_en,
   input  logic [2:0]    rd_addr,
   output logic [31:0]   rd_data,
   output logic          rd_valid,
   output logic          busy,
   output logic          done
);

   localparam int NS = ROWS * COLS;
   localparam logic [2:0] LAST_T = 3'(ROWS + COLS - 1);

   col_state_t    state;
   logic [2:0]    t;
   logic [DW-1:0] slot [NS];
   logic [DW-1:0] col  [3];
   logic [NS-1:0] wen;
   logic [DW-1:0] wdat [NS];
   logic [31:0]   pack;
   logic [3:0]    lo;
   logic [3:0]    hi;

   assign col[0] = out1;
   assign col[1] = out2;
   assign col[2] = out3;

   // Column k emits its row r result at step t = k + r + 1.
   for (genvar k = 0; k < COLS; k++) begin : g_col
      for (genvar r = 0; r < ROWS; r++) begin : g_row
         localparam int IDX = k * ROWS + r;
         assign wen[IDX] = (state == ST_CAPTURE) &&
                           (t == 3'(k + r + 1));
         assign wdat[IDX] =
            (RELU != 0 && col[k][DW-1]) ? '0 : col[k];
      end
   end

   always_comb begin
      lo   = {rd_addr, 1'b0};
      hi   = {rd_addr, 1'b1};
      pack = '0;
      if (rd_addr < 3'(PACKED_WORDS)) begin
         if (lo < 4'(NS)) pack[15:0]  = 16'(slot[lo]);
         if (hi < 4'(NS)) pack[31:16] = 16'(slot[hi]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         t        <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         for (int i = 0; i < NS; i++) slot[i] <= '0;
      end else begin
         rd_valid <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_CAPTURE;
                  t     <= 3'd1;
                  busy  <= 1'b1;
                  for (int i = 0; i < NS; i++) slot[i] <= '0;
               end
            end
            ST_CAPTURE: begin
               for (int i = 0; i < NS; i++)
                  if (wen[i]) slot[i] <= wdat[i];
               t <= t + 3'd1;
               if (t == LAST_T) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            ST_DONE: begin
               // Read sees pre-clear contents if start coincides.
               if (rd_en) begin
                  rd_valid <= 1'b1;
                  rd_data  <= pack;
               end
               if (start) begin
                  state <= ST_CAPTURE;
                  t     <= 3'd1;
                  busy  <= 1'b1;
                  done  <= 1'b0;
                  for (int i = 0; i < NS; i++) slot[i] <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
